baccarat_match_fsm: RTL and testbench
=====================================

Name: baccarat_match_fsm

Overview:
Parametrised successor to the single-hand baccarat controller. It sequences NUM_ROUNDS consecutive hands. It adds an explicit evaluation state, so decisions use settled scores, and the full banker third-card rule driven by pcard3. It also adds per-round win/tie tallies, a start/done handshake and a hold period between hands. It sits between the card/score datapath (load strobes out, scores in) and the board lights/HEX display.

Parameters:
NUM_ROUNDS, 5, hands per match (1..15)
HOLD_CYCLES, 2, slow_clock cycles the round result is held before the next hand (>=1)
CNT_W, $clog2(NUM_ROUNDS+1), width of tally and round counters (derived, not overridden)

Ports:
slow_clock  input  1  system clock; all state changes on posedge
resetb  input  1  synchronous, active-low reset, sampled on posedge slow_clock
start  input  1  level; begins a match from IDLE or DONE
pscore  input  4  player hand score from datapath (legal 0..9)
dscore  input  4  dealer hand score from datapath (legal 0..9)
pcard3  input  4  value of player third card (legal 0..9)
clear_hands  output  1  datapath clears all six card registers
load_pcard1, load_pcard2, load_pcard3  output  1 each  player card load strobes
load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card load strobes
player_win_light, dealer_win_light  output  1 each  registered result lights; both high = tie
round_done  output  1  one-cycle pulse when a hand is scored
match_done  output  1  high while in DONE
round_idx  output  CNT_W  hands completed in the current match
player_wins, dealer_wins, ties  output  CNT_W each  match tallies

Behaviour:
- Reset (resetb=0 at posedge): state IDLE; all outputs 0; counters 0. Applies from any state, mid-hand included.
- Outputs are Moore. Exactly one strobe is high per state: CLR->clear_hands, P1->load_pcard1, D1->load_dcard1, P2->load_pcard2, D2->load_dcard2, P3->load_pcard3, D3->load_dcard3.
- IDLE: start=1 -> CLR; else stay.
- CLR -> P1 -> D1 -> P2 -> D2 -> EVAL, unconditional, one cycle each. CLR also clears both lights.
- EVAL (no strobes) decides on settled 2-card scores:
  - pscore or dscore in {8,9} -> RESULT;
  - else pscore 0..5 -> P3;
  - else pscore 6..7: dscore 0..5 -> D3, else RESULT;
  - pscore >9 -> RESULT (illegal input; hand stands).
- P3 -> EVAL3. EVAL3 applies the banker rule using pcard3; draw -> D3, stand -> RESULT:
  - dscore 0..2: draw;
  - 3: draw unless pcard3==8;
  - 4: draw if pcard3 2..7;
  - 5: draw if pcard3 4..7;
  - 6: draw if pcard3 6..7;
  - 7..9: stand.
- D3 -> RESULT.
- RESULT (one cycle):
  - round_done=1.
  - Compare pscore vs dscore. Greater side's light is set (registered at exit edge, held through HOLD). Equal scores set both lights.
  - Exactly one tally increments.
  - round_idx increments.
- HOLD: lasts HOLD_CYCLES cycles, counted by an internal counter. Then round_idx==NUM_ROUNDS -> DONE, else CLR.
- DONE: match_done=1. Lights show the match winner by comparing player_wins vs dealer_wins; equal lights both. Tallies hold. start=1 -> CLR, and on that edge round_idx and the tallies zero.
- start is ignored outside IDLE/DONE.
- Tallies never exceed NUM_ROUNDS, so no wrap is possible.

Decomposition:
- Package baccarat_pkg: state enum (IDLE, CLR, P1, D1, P2, D2, EVAL, P3, EVAL3, D3, RESULT, HOLD, DONE) and score constants (NATURAL_MIN=8, PLAYER_STAND_MIN=6, BANKER_STAND=7).
- One sub-module, banker_draw_rule: combinational (dscore, pcard3) -> draw. Shared with the future software-model checker.

Test Plan:
- Reset then start=1, pscore=3, dscore=4, pcard3=2: strobe sequence CLR,P1,D1,P2,D2,EVAL,P3,EVAL3,D3 (dscore 4 & pcard3 2 -> draw), then RESULT. Set final pscore=7, dscore=5: player light only; player_wins=1, round_idx=1.
- Natural, pscore=8, dscore=8: EVAL -> RESULT with no third-card strobes; both lights on; ties=1.
- Banker rule sweep at EVAL3 for dscore=3..6 against each pcard3 0..9: the D3-vs-RESULT branch matches the table. Spot checks: d=3/p3=8 stands, d=6/p3=7 draws.
- pscore=6, dscore=6 -> RESULT directly. pscore=7, dscore=5 -> D3. pscore=12 -> RESULT, no hang.
- NUM_ROUNDS=3, HOLD_CYCLES=2, dealer wins every hand: 3 round_done pulses; HOLD exactly 2 cycles each; DONE with dealer_wins=3 and dealer light only; start again -> tallies zero.
- resetb=0 asserted while in P3 and while in HOLD: next state IDLE, all outputs and counters 0. start held high in RESULT/HOLD has no effect.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and score constants for the baccarat match controller.
// Contents:
//   state_t     - controller states, one per card strobe plus decision,
//                 result, hold and done states
//   score consts - natural threshold, player stand threshold, banker stand
//   is_natural  - true for a legal two-card score of 8 or 9
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        P1,
        D1,
        P2,
        D2,
        EVAL,
        P3,
        EVAL3,
        D3,
        RESULT,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    localparam logic [3:0] BANKER_STAND     = 4'd7;
    localparam logic [3:0] SCORE_MAX        = 4'd9;

    function automatic logic is_natural(input logic [3:0] score);
        return (score >= NATURAL_MIN) && (score <= SCORE_MAX);
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card rule, applied after the player has drawn a third card.
// Ports:
//   dscore - banker two-card score (legal 0..9)
//   pcard3 - value of the player's third card (legal 0..9)
//   draw   - 1 when the banker must take a third card
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        if (dscore < BANKER_STAND) begin
            case (dscore)
                4'd0, 4'd1, 4'd2: draw = 1'b1;
                4'd3:             draw = (pcard3 != 4'd8);
                4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
                4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
                4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
                default:          draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_match_fsm.sv
// Multi-hand baccarat match controller. Sequences NUM_ROUNDS hands, driving
// the card datapath's load strobes and scoring each hand from the settled
// scores it returns. Keeps per-match tallies and drives the result lights.
// Ports:
//   slow_clock, resetb      - clock, synchronous active-low reset
//   start                   - begins a match from IDLE or DONE
//   pscore, dscore, pcard3  - scores and player third card from the datapath
//   clear_hands, load_*     - one-hot datapath strobes (Moore)
//   *_win_light             - registered result lights, both high for a tie
//   round_done, match_done  - hand-scored pulse, match-complete level
//   round_idx, *_wins, ties - hands completed and tallies for this match
module baccarat_match_fsm
    import baccarat_pkg::*;
#(
    parameter  int NUM_ROUNDS  = 5,
    parameter  int HOLD_CYCLES = 2,
    localparam int CNT_W       = $clog2(NUM_ROUNDS + 1)
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             start,
    input  logic [3:0]       pscore,
    input  logic [3:0]       dscore,
    input  logic [3:0]       pcard3,
    output logic             clear_hands,
    output logic             load_pcard1,
    output logic             load_pcard2,
    output logic             load_pcard3,
    output logic             load_dcard1,
    output logic             load_dcard2,
    output logic             load_dcard3,
    output logic             player_win_light,
    output logic             dealer_win_light,
    output logic             round_done,
    output logic             match_done,
    output logic [CNT_W-1:0] round_idx,
    output logic [CNT_W-1:0] player_wins,
    output logic [CNT_W-1:0] dealer_wins,
    output logic [CNT_W-1:0] ties
);

    localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  round_idx_q, round_idx_d;
    logic [CNT_W-1:0]  player_wins_q, player_wins_d;
    logic [CNT_W-1:0]  dealer_wins_q, dealer_wins_d;
    logic [CNT_W-1:0]  ties_q, ties_d;
    logic              player_light_q, player_light_d;
    logic              dealer_light_q, dealer_light_d;
    logic              banker_draw;

    banker_draw_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        round_idx_d    = round_idx_q;
        player_wins_d  = player_wins_q;
        dealer_wins_d  = dealer_wins_q;
        ties_d         = ties_q;
        player_light_d = player_light_q;
        dealer_light_d = dealer_light_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    // Match winner from the tallies; equal tallies light both.
                    player_light_d = (player_wins_q >= dealer_wins_q);
                    dealer_light_d = (dealer_wins_q >= player_wins_q);
                end
                if (start) begin
                    state_d       = CLR;
                    round_idx_d   = '0;
                    player_wins_d = '0;
                    dealer_wins_d = '0;
                    ties_d        = '0;
                end
            end
            CLR: begin
                player_light_d = 1'b0;
                dealer_light_d = 1'b0;
                state_d        = P1;
            end
            P1: state_d = D1;
            D1: state_d = P2;
            P2: state_d = D2;
            D2: state_d = EVAL;
            EVAL: begin
                if (is_natural(pscore) || is_natural(dscore)) begin
                    state_d = RESULT;
                end else if (pscore < PLAYER_STAND_MIN) begin
                    state_d = P3;
                end else if (pscore < NATURAL_MIN) begin
                    // Player stood on 6/7: banker uses the same 0..5 draw range.
                    state_d = (dscore < PLAYER_STAND_MIN) ? D3 : RESULT;
                end else begin
                    // Out-of-range player score: the hand stands as dealt.
                    state_d = RESULT;
                end
            end
            P3:    state_d = EVAL3;
            EVAL3: state_d = banker_draw ? D3 : RESULT;
            D3:    state_d = RESULT;
            RESULT: begin
                player_light_d = (pscore >= dscore);
                dealer_light_d = (dscore >= pscore);
                if (pscore > dscore) begin
                    player_wins_d = player_wins_q + CNT_W'(1);
                end else if (dscore > pscore) begin
                    dealer_wins_d = dealer_wins_q + CNT_W'(1);
                end else begin
                    ties_d = ties_q + CNT_W'(1);
                end
                round_idx_d = round_idx_q + CNT_W'(1);
                hold_cnt_d  = '0;
                state_d     = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (round_idx_q == CNT_W'(NUM_ROUNDS)) begin
                        state_d        = DONE;
                        // Show the match winner from the first DONE cycle.
                        player_light_d = (player_wins_q >= dealer_wins_q);
                        dealer_light_d = (dealer_wins_q >= player_wins_q);
                    end else begin
                        state_d = CLR;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q        <= IDLE;
            hold_cnt_q     <= '0;
            round_idx_q    <= '0;
            player_wins_q  <= '0;
            dealer_wins_q  <= '0;
            ties_q         <= '0;
            player_light_q <= 1'b0;
            dealer_light_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            round_idx_q    <= round_idx_d;
            player_wins_q  <= player_wins_d;
            dealer_wins_q  <= dealer_wins_d;
            ties_q         <= ties_d;
            player_light_q <= player_light_d;
            dealer_light_q <= dealer_light_d;
        end
    end

    assign clear_hands      = (state_q == CLR);
    assign load_pcard1      = (state_q == P1);
    assign load_dcard1      = (state_q == D1);
    assign load_pcard2      = (state_q == P2);
    assign load_dcard2      = (state_q == D2);
    assign load_pcard3      = (state_q == P3);
    assign load_dcard3      = (state_q == D3);
    assign round_done       = (state_q == RESULT);
    assign match_done       = (state_q == DONE);
    assign player_win_light = player_light_q;
    assign dealer_win_light = dealer_light_q;
    assign round_idx        = round_idx_q;
    assign player_wins      = player_wins_q;
    assign dealer_wins      = dealer_wins_q;
    assign ties             = ties_q;

endmodule

// File: tb/tb_baccarat_match_fsm.sv
// Scoreboard bench: a datapath responder deals random hands and pushes the
// reference-model outcome of each hand; an independent monitor pops and
// compares whenever the controller scores a hand.
module tb_baccarat_match_fsm;

    localparam int NR = 3;
    localparam int HC = 2;
    localparam int CW = $clog2(NR + 1);

    logic          slow_clock = 1'b0;
    logic          resetb     = 1'b0;
    logic          start      = 1'b0;
    logic [3:0]    pscore     = 4'd0;
    logic [3:0]    dscore     = 4'd0;
    logic [3:0]    pcard3     = 4'd0;
    logic          clear_hands, load_pcard1, load_pcard2, load_pcard3;
    logic          load_dcard1, load_dcard2, load_dcard3;
    logic          player_win_light, dealer_win_light, round_done, match_done;
    logic [CW-1:0] round_idx, player_wins, dealer_wins, ties;

    baccarat_match_fsm #(.NUM_ROUNDS(NR), .HOLD_CYCLES(HC)) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .start            (start),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .clear_hands      (clear_hands),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .round_done       (round_done),
        .match_done       (match_done),
        .round_idx        (round_idx),
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins),
        .ties             (ties)
    );

    always #5 slow_clock = ~slow_clock;

    typedef struct packed {
        logic [3:0] p2;
        logic [3:0] d2;
        logic [3:0] pc3;
        logic [3:0] pf;
        logic [3:0] df;
    } hand_t;

    typedef struct {
        bit pdraw;
        bit ddraw;
        int winner;   // 0 player, 1 dealer, 2 tie
        int hp, hd;   // final scores, for the log line
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] banker_mask [0:9];   // bit k set: banker draws when pcard3 == k

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\", expected \"%s\" at %0t", name, act, exp, $time);
        end
    endtask

    // Baccarat tableau from the card-game rules, as a lookup table.
    function automatic exp_t model(input hand_t h);
        exp_t e;
        bit   natural;
        int   fp, fd;
        natural = (h.p2 == 8) || (h.p2 == 9) || (h.d2 == 8) || (h.d2 == 9);
        e.pdraw = !natural && (h.p2 <= 5);
        if (e.pdraw) e.ddraw = banker_mask[h.d2][h.pc3];
        else         e.ddraw = !natural && (h.p2 == 6 || h.p2 == 7) && (h.d2 <= 5);
        fp = e.pdraw ? int'(h.pf) : int'(h.p2);
        fd = e.ddraw ? int'(h.df) : int'(h.d2);
        e.winner = (fp > fd) ? 0 : (fd > fp) ? 1 : 2;
        e.hp = fp;
        e.hd = fd;
        return e;
    endfunction

    function automatic string strobe_char();
        logic [6:0] s;
        s = {clear_hands, load_pcard1, load_dcard1, load_pcard2, load_dcard2,
             load_pcard3, load_dcard3};
        case (s)
            7'b1000000: return "C";
            7'b0100000: return "P";
            7'b0010000: return "D";
            7'b0001000: return "p";
            7'b0000100: return "d";
            7'b0000010: return "3";
            7'b0000001: return "4";
            7'b0000000: return "-";
            default:    return "!";
        endcase
    endfunction

    // Datapath responder: deals a fresh hand on clear_hands, reveals third cards.
    initial begin : responder
        hand_t cur;
        cur = '0;
        forever begin
            @(negedge slow_clock);
            if (clear_hands) begin
                if ($urandom_range(0, 1) == 1) begin
                    cur.p2 = 4'($urandom_range(0, 5));
                    cur.d2 = 4'($urandom_range(3, 6));
                end else begin
                    cur.p2 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
                    cur.d2 = 4'($urandom_range(0, 9));
                end
                cur.pc3 = 4'($urandom_range(0, 9));
                cur.pf  = 4'($urandom_range(0, 9));
                cur.df  = 4'($urandom_range(0, 9));
                sb.push_back(model(cur));
                pscore = cur.p2;
                dscore = cur.d2;
                pcard3 = cur.pc3;
            end
            if (load_pcard3) pscore = cur.pf;
            if (load_dcard3) dscore = cur.df;
        end
    end

    // Monitor: scores each hand, the following hold period and match end.
    initial begin : monitor
        exp_t  e;
        string seq, exp_seq;
        bit    in_hand, pend, in_hold;
        int    hold_cnt, pw, dw, tw, rounds, hand_no;
        in_hand = 0; pend = 0; in_hold = 0; hold_cnt = 0;
        pw = 0; dw = 0; tw = 0; rounds = 0; hand_no = 0;
        forever begin
            @(negedge slow_clock);
            if (!resetb) begin
                sb.delete();
                in_hand = 0; pend = 0; in_hold = 0;
                pw = 0; dw = 0; tw = 0; rounds = 0;
                continue;
            end
            if (pend) begin
                check("hand_player_light", player_win_light, int'(e.winner != 1));
                check("hand_dealer_light", dealer_win_light, int'(e.winner != 0));
                check("tally_player", player_wins, pw);
                check("tally_dealer", dealer_wins, dw);
                check("tally_ties", ties, tw);
                check("round_idx_post", round_idx, rounds);
                pend = 0;
            end
            if (in_hold) begin
                if (clear_hands || match_done) begin
                    check("hold_len", hold_cnt, HC);
                    check("match_end", match_done, int'(rounds == NR));
                    if (match_done) begin
                        check("done_player_light", player_win_light, int'(pw >= dw));
                        check("done_dealer_light", dealer_win_light, int'(dw >= pw));
                    end
                    in_hold = 0;
                end else begin
                    hold_cnt++;
                    if (hold_cnt > HC + 4) begin
                        check("hold_len", hold_cnt, HC);
                        in_hold = 0;
                    end
                end
            end
            if (clear_hands && rounds == NR) begin
                pw = 0; dw = 0; tw = 0; rounds = 0;
                check("restart_counters", {round_idx, player_wins, dealer_wins, ties}, 0);
            end
            if (clear_hands) begin
                seq = "C";
                in_hand = 1;
            end else if (in_hand && !round_done && seq.len() < 40) begin
                seq = {seq, strobe_char()};
            end
            if (round_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: round_done with no dealt hand at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    exp_seq = "CPDpd-";
                    if (e.pdraw) exp_seq = {exp_seq, "3-"};
                    if (e.ddraw) exp_seq = {exp_seq, "4"};
                    check_str("strobe_seq", seq, exp_seq);
                    check("round_idx_pre", round_idx, rounds);
                    rounds++;
                    if (e.winner == 0)      pw++;
                    else if (e.winner == 1) dw++;
                    else                    tw++;
                    hand_no++;
                    $display("hand %0d: seq=%s player=%0d dealer=%0d winner=%0d tallies %0d/%0d/%0d",
                             hand_no, seq, e.hp, e.hd, e.winner, pw, dw, tw);
                    pend = 1;
                    in_hold = 1;
                    hold_cnt = 0;
                end
                in_hand = 0;
            end
        end
    end

    task automatic check_idle(input string name);
        check(name, {clear_hands, load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                     load_pcard3, load_dcard3, player_win_light, dealer_win_light,
                     round_done, match_done, round_idx, player_wins, dealer_wins, ties}, 0);
    endtask

    task automatic wait_match_done(input string tag);
        bit seen_low;
        seen_low = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge slow_clock);
            if (!match_done) seen_low = 1;
            else if (seen_low) break;
        end
        check({"match_done_", tag}, match_done, 1);
    endtask

    // Runs matches until the chosen event is seen: 0 = load_pcard3, 1 = round_done.
    task automatic hunt(input int which);
        bit found;
        found = 0;
        start = 1'b1;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge slow_clock);
            if ((which == 0 && load_pcard3) || (which == 1 && round_done)) found = 1;
            else start = match_done;
        end
        start = 1'b0;
        if (which == 0) check("hunt_p3", load_pcard3, 1);
        else            check("hunt_result", round_done, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : main
        for (int d = 0; d < 10; d++) banker_mask[d] = 10'b00_0000_0000;
        for (int d = 0; d < 3; d++)  banker_mask[d] = 10'b11_1111_1111;
        banker_mask[3] = 10'b10_1111_1111;
        banker_mask[4] = 10'b00_1111_1100;
        banker_mask[5] = 10'b00_1111_0000;
        banker_mask[6] = 10'b00_1100_0000;

        resetb = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge slow_clock);
        check_idle("reset_state");
        resetb = 1'b1;
        @(negedge slow_clock);
        check_idle("idle_without_start");

        // start held high through the whole match, including RESULT and HOLD
        start = 1'b1;
        wait_match_done("held_start");
        start = 1'b0;
        repeat (3) @(negedge slow_clock);
        check("done_holds", match_done, 1);

        for (int m = 0; m < 100; m++) begin
            start = 1'b1;
            @(negedge slow_clock);
            start = 1'b0;
            wait_match_done("random");
        end

        // reset in the middle of a hand, while in P3
        hunt(0);
        resetb = 1'b0;
        @(negedge slow_clock);
        check_idle("reset_from_p3");
        resetb = 1'b1;
        @(negedge slow_clock);
        check_idle("idle_after_p3_reset");

        // reset during the hold period
        hunt(1);
        @(negedge slow_clock);
        resetb = 1'b0;
        @(negedge slow_clock);
        check_idle("reset_from_hold");
        resetb = 1'b1;
        @(negedge slow_clock);
        check_idle("idle_after_hold_reset");

        start = 1'b1;
        @(negedge slow_clock);
        start = 1'b0;
        wait_match_done("after_reset");
        @(negedge slow_clock);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
